// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline stage state and per-stage bundle widths.
// Widths here size each pl_stage_reg instance in the core.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } pl_stage_state_t;

  localparam int IF_ID_CTRL_W  = 1;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 12;
  localparam int ID_EX_DATA_W  = 128;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int EX_MEM_DATA_W = 106;
  localparam int MEM_WB_CTRL_W = 4;
  localparam int MEM_WB_DATA_W = 69;

  localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/pl_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by perf counters.
// Clear wins over increment.
module pl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pl_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush,
// optional 2-entry skid buffer and a stall-cycle counter.
module pl_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  pl_stage_state_t state_q, state_d;

  logic              in_fire;
  logic              out_fire;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              ld_skid;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d    = MAIN;
            ld_main_in = 1'b1;
          end
        end
        MAIN: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            state_d = BOTH;
            ld_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        BOTH: begin
          if (out_fire) begin
            state_d      = MAIN;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush squashes control only; data is left stale to save enables.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else if (flush) begin
      main_ctrl_q <= '0;
    end else if (ld_main_in) begin
      main_ctrl_q <= in_ctrl;
      main_data_q <= in_data;
    end else if (ld_main_skid) begin
      main_ctrl_q <= skid_ctrl;
      main_data_q <= skid_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl_q;
      logic [DATA_W-1:0] skid_data_q;
      logic              rdy_q;

      // Registered ready breaks the out_ready -> in_ready path.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
          rdy_q       <= 1'b1;
        end else begin
          rdy_q <= (state_d != BOTH);
          if (flush) begin
            skid_ctrl_q <= '0;
          end else if (ld_skid) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
          end
        end
      end

      assign skid_ctrl = skid_ctrl_q;
      assign skid_data = skid_data_q;
      assign in_ready  = rdy_q;
    end else begin : g_noskid
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign in_ready  = (state_q == EMPTY) | out_ready;
    end
  endgenerate

  pl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (cnt_clr),
    .inc  (out_valid & ~out_ready),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_pl_stage_reg.sv
// Bench for pl_stage_reg: three configurations against a FIFO-level model.
// dut0 SKID=1 defaults, dut1 SKID=1 CNT_W=4, dut2 SKID=0.
module tb_pl_stage_reg;

  logic         CLK;
  logic         nRST;
  logic         in_valid;
  logic [7:0]   in_ctrl;
  logic [127:0] in_data;
  logic         out_ready;
  logic         flush;
  logic         cnt_clr;

  logic         ir0, ir1, ir2;
  logic         ov0, ov1, ov2;
  logic [7:0]   oc0, oc1, oc2;
  logic [127:0] od0, od1, od2;
  logic [15:0]  sc0;
  logic [3:0]   sc1;
  logic [15:0]  sc2;

  int errors = 0;
  int checks = 0;

  logic [7:0]   mc[3][2];
  logic [127:0] md[3][2];
  int           mn[3];
  int           msc[3];
  int           mmax[3] = '{65535, 15, 65535};

  pl_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1), .CNT_W(16)) dut0 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(ir0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0),
    .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(sc0)
  );

  pl_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1), .CNT_W(4)) dut1 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(ir1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1),
    .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(sc1)
  );

  pl_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0), .CNT_W(16)) dut2 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(ir2),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov2),
    .out_ready(out_ready), .out_ctrl(oc2), .out_data(od2),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(sc2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ir(int k);
    if (k != 2) return mn[k] < 2;
    return (mn[k] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mn[k]  = 0;
      msc[k] = 0;
    end
  endtask

  task automatic check_all();
    logic         v[3];
    logic         r[3];
    logic [7:0]   c[3];
    logic [127:0] d[3];
    logic [15:0]  s[3];
    v = '{ov0, ov1, ov2};
    r = '{ir0, ir1, ir2};
    c = '{oc0, oc1, oc2};
    d = '{od0, od1, od2};
    s = '{sc0, {12'b0, sc1}, sc2};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready[%0d]", k), r[k], m_ir(k));
      chk($sformatf("out_valid[%0d]", k), v[k], mn[k] > 0);
      chk($sformatf("out_ctrl[%0d]", k), c[k],
          (mn[k] > 0) ? mc[k][0] : 8'h00);
      if (mn[k] > 0)
        chk($sformatf("out_data[%0d]", k), d[k], md[k][0]);
      chk($sformatf("stall_cnt[%0d]", k), s[k], msc[k]);
    end
  endtask

  // One clock of the abstract FIFO: pop on out_fire, push on in_fire.
  task automatic model_step();
    bit r, of, inf;
    for (int k = 0; k < 3; k++) begin
      r   = m_ir(k);
      of  = (mn[k] > 0) && out_ready;
      inf = in_valid && r;
      if (cnt_clr) msc[k] = 0;
      else if ((mn[k] > 0) && !out_ready && (msc[k] < mmax[k])) msc[k]++;
      if (flush) begin
        mn[k] = 0;
      end else begin
        if (of) begin
          mc[k][0] = mc[k][1];
          md[k][0] = md[k][1];
          mn[k]--;
        end
        if (inf) begin
          mc[k][mn[k]] = in_ctrl;
          md[k][mn[k]] = in_data;
          mn[k]++;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b1; in_ctrl = 8'hAB;
    in_data = 128'hDEADBEEF; out_ready = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst out_valid", ov0, 1'b0);
    chk("rst out_ctrl", oc0, 8'h00);
    chk("rst out_data", od0, 128'h0);
    chk("rst stall_cnt", sc0, 16'h0);
    chk("rst in_ready", ir0, 1'b1);
    chk("rst in_ready skid0", ir2, 1'b1);
    chk("rst out_data skid0", od2, 128'h0);
    nRST = 1'b1; in_valid = 1'b0;
    cycle();

    // streaming, 1 entry/cycle, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 8'(i); in_data = 128'(i);
      cycle();
      chk("stream valid", ov0, 1'b1);
      chk("stream data", od0, 128'(i));
      chk("stream data skid0", od2, 128'(i));
    end
    in_valid = 1'b0;
    cycle();

    // backpressure: A, B into skid, C held
    in_valid = 1'b1; in_ctrl = 8'h1; in_data = 128'hA; out_ready = 1'b1;
    cycle();
    chk("bp head A", od0, 128'hA);
    in_data = 128'hB; out_ready = 1'b0;
    cycle();
    chk("bp full", ir0, 1'b0);
    in_data = 128'hC;
    cycle();
    cycle();
    chk("bp hold A", od0, 128'hA);
    chk("bp stall_cnt", sc0, 16'd3);
    out_ready = 1'b1;
    cycle();
    chk("bp order B", od0, 128'hB);
    cycle();
    chk("bp order C", od0, 128'hC);
    in_valid = 1'b0;
    cycle();
    chk("bp drained", ov0, 1'b0);

    // flush in BOTH with ctrl 0xFF and a live input
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 128'h11; out_ready = 1'b0;
    cycle();
    in_data = 128'h22;
    cycle();
    chk("fl both", ir0, 1'b0);
    flush = 1'b1; in_ctrl = 8'h0F; in_data = 128'h55;
    cycle();
    chk("fl valid", ov0, 1'b0);
    chk("fl ctrl", oc0, 8'h00);
    chk("fl ready", ir0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("fl no capture", ov0, 1'b0);

    // flush with out_fire and cnt_clr together
    in_valid = 1'b1; in_ctrl = 8'h3; in_data = 128'h66;
    cycle();
    flush = 1'b1; cnt_clr = 1'b1; in_valid = 1'b0;
    cycle();
    chk("fl+clr valid", ov0, 1'b0);
    chk("fl+clr cnt", sc0, 16'h0);
    flush = 1'b0; cnt_clr = 1'b0;

    // 4-bit counter saturation
    in_valid = 1'b1; in_data = 128'h77; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    chk("sat 15", sc1, 4'd15);
    cnt_clr = 1'b1;
    cycle();
    chk("sat clr", sc1, 4'd0);
    cnt_clr = 1'b0;
    cycle();
    chk("sat resume", sc1, 4'd1);

    // SKID=0 combinational ready while full
    in_valid = 1'b1; in_data = 128'h88; out_ready = 1'b0;
    #1 chk("skid0 ready lo", ir2, 1'b0);
    out_ready = 1'b1;
    #1 chk("skid0 ready hi", ir2, 1'b1);
    cycle();
    chk("skid0 replace", od2, 128'h88);
    chk("skid0 valid", ov2, 1'b1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_ctrl   = 8'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      flush     = ($urandom % 25) == 0;
      cnt_clr   = ($urandom % 40) == 0;
      cycle();
    end
    flush = 1'b0; cnt_clr = 1'b0;

    // asynchronous reset mid-transfer
    in_valid = 1'b1; out_ready = 1'b0; in_data = 128'h99;
    cycle();
    cycle();
    #2 nRST = 1'b0;
    #1;
    chk("arst valid", ov0, 1'b0);
    chk("arst ctrl", oc0, 8'h00);
    chk("arst data", od0, 128'h0);
    chk("arst ready", ir0, 1'b1);
    chk("arst cnt", sc0, 16'h0);
    chk("arst data skid0", od2, 128'h0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    for (int n = 0; n < 20; n++) begin
      in_valid  = $urandom % 2;
      out_ready = $urandom % 2;
      in_ctrl   = 8'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
